// File: rtl/sipo_word_packer_if.sv
// sipo_word_packer_if: input beat stream, flush request and output word stream of the packer.
// The master modport is the upstream/downstream side; the slave modport is the packer.
interface sipo_word_packer_if #(
    parameter int IN_W  = 8,
    parameter int BEATS = 8
);
    localparam int OUT_W = IN_W * BEATS;
    logic                       in_valid;
    logic [IN_W-1:0]            in_data;
    logic                       in_ready;
    logic                       flush;
    logic                       out_valid;
    logic [OUT_W-1:0]           out_data;
    logic [$clog2(BEATS+1)-1:0] out_beats;
    logic                       out_ready;
    logic [$clog2(BEATS)-1:0]   beat_cnt;
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_beats, beat_cnt
    );
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_beats, beat_cnt
    );
endinterface

// File: rtl/sipo_word_packer.sv
// sipo_word_packer: packs BEATS IN_W-bit beats into one registered output word.
// Define SIPO_FLUSH_EN to let flush emit a zero-padded partial word.
module sipo_word_packer #(
    parameter int IN_W      = 8,
    parameter int BEATS     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    sipo_word_packer_if.slave bus
);
    localparam int OUT_W = IN_W * BEATS;
    localparam int CW    = $clog2(BEATS);
    localparam int BW    = $clog2(BEATS + 1);
    logic [CW-1:0]    r_cnt;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] r_data;
    logic [BW-1:0]    r_beats;
    logic             r_valid;
    logic             r_pend;
    logic [OUT_W-1:0] w_merged;
    logic [BW-1:0]    w_fill;
    logic             w_slot_free;
    logic             w_last;
    logic             w_acc;
    logic             w_full;
    logic             w_fl_req;
    assign w_slot_free  = !r_valid || bus.out_ready;
    assign w_last       = r_cnt == CW'(BEATS - 1);
    assign bus.in_ready = rst_n && !r_pend && (!w_last || w_slot_free);
    assign w_acc        = bus.in_valid && bus.in_ready;
    assign w_full       = w_acc && w_last;
    // beats held after this edge's accept; equals BEATS on a completing beat
    assign w_fill       = BW'(r_cnt) + BW'(w_acc);
`ifdef SIPO_FLUSH_EN
    assign w_fl_req = r_pend || (bus.flush && !w_full && w_fill != '0);
`else
    assign w_fl_req = 1'b0 && bus.flush;
`endif
    always_comb begin
        w_merged = r_acc;
        for (int k = 0; k < BEATS; k++)
            if (r_cnt == CW'(k)) w_merged[(LSB_FIRST ? k : BEATS - 1 - k) * IN_W +: IN_W] = bus.in_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_beats <= '0;
            r_valid <= 1'b0;
            r_pend  <= 1'b0;
        end else if (w_full || (w_fl_req && w_slot_free)) begin
            r_data  <= w_acc ? w_merged : r_acc;
            r_beats <= w_fill;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_pend  <= 1'b0;
        end else begin
            if (bus.out_ready) r_valid <= 1'b0;
            if (w_acc) begin
                r_acc <= w_merged;
                r_cnt <= r_cnt + 1'b1;
            end
            r_pend <= w_fl_req;
        end
    end
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_beats = r_beats;
    assign bus.beat_cnt  = r_cnt;
endmodule

// File: tb/tb_sipo_word_packer.sv
// tb_sipo_word_packer: directed and random beats checked against a queue-based word model.
// Compile with SIPO_FLUSH_EN defined to exercise partial-word flush.
module tb_sipo_word_packer;
    localparam int IN_W      = 8;
    localparam int BEATS     = 8;
    localparam int OUT_W     = IN_W * BEATS;
    localparam bit LSB_FIRST = 1'b0;
`ifdef SIPO_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [IN_W-1:0]  acc_q[$];
    logic             m_valid = 1'b0;
    logic             m_pend  = 1'b0;
    logic [OUT_W-1:0] m_word  = '0;
    int               m_beats = 0;
    int               n_words;
    sipo_word_packer_if #(.IN_W(IN_W), .BEATS(BEATS)) bus ();
    sipo_word_packer #(.IN_W(IN_W), .BEATS(BEATS), .LSB_FIRST(LSB_FIRST)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic void emit();
        m_word = '0;
        foreach (acc_q[i]) m_word |= OUT_W'(acc_q[i]) << ((LSB_FIRST ? i : BEATS - 1 - i) * IN_W);
        m_beats = acc_q.size();
        m_valid = 1'b1;
        m_pend  = 1'b0;
        acc_q.delete();
    endfunction
    // one clock: drive inputs, check ready, advance the model at the edge, check outputs
    task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic f, input logic r);
        logic rdy;
        logic slot_free;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
        #1;
        rdy = rst_n && !m_pend && !(acc_q.size() == BEATS - 1 && m_valid && !r);
        slot_free = !m_valid || r;
        chk("in_ready", OUT_W'(bus.in_ready), OUT_W'(rdy));
        @(posedge clk);
        if (!rst_n) begin
            acc_q.delete();
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_word  = '0;
            m_beats = 0;
        end else begin
            if (v && rdy) acc_q.push_back(d);
            if (acc_q.size() == BEATS) emit();
            else if (FLUSH_EN && (m_pend || (f && acc_q.size() > 0))) begin
                if (slot_free) emit();
                else m_pend = 1'b1;
            end else if (r) m_valid = 1'b0;
        end
        #1;
        chk("out_valid", OUT_W'(bus.out_valid), OUT_W'(m_valid));
        chk("beat_cnt", OUT_W'(bus.beat_cnt), OUT_W'(acc_q.size()));
        chk("out_data", bus.out_data, m_word);
        chk("out_beats", OUT_W'(bus.out_beats), OUT_W'(m_beats));
    endtask
    initial begin
        rst_n = 1'b0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        rst_n = 1'b1;
        cyc(0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) cyc(1, IN_W'(i), 0, 1);
        chk("t2_word", bus.out_data, 64'h0102030405060708);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 15; i++) cyc(1, IN_W'(i), 0, 0);
        cyc(1, 8'h0F, 0, 0);
        chk("t3_stall_ready", OUT_W'(bus.in_ready), '0);
        cyc(1, 8'h0F, 0, 1);
        chk("t3_word2", bus.out_data, 64'h08090A0B0C0D0E0F);
        chk("t3_valid_kept", OUT_W'(bus.out_valid), OUT_W'(1));
        cyc(0, 0, 0, 1);
        n_words = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1, IN_W'($urandom), 0, 1);
            if (bus.out_valid) n_words++;
        end
        chk("t4_words", OUT_W'(n_words), OUT_W'(8));
        for (int i = 0; i < 5; i++) cyc(1, IN_W'(i + 1), 0, 1);
        rst_n = 1'b0;
        cyc(1, 8'h77, 0, 1);
        rst_n = 1'b1;
        chk("t5_cnt_cleared", OUT_W'(bus.beat_cnt), '0);
        for (int i = 0; i < 8; i++) cyc(1, IN_W'(8'hAA + i), 0, 1);
        chk("t5_clean_word", bus.out_data, 64'hAAABACADAEAFB0B1);
        cyc(0, 0, 0, 1);
        cyc(1, 8'h11, 0, 1);
        cyc(1, 8'h22, 0, 1);
        cyc(1, 8'h33, 0, 1);
        cyc(0, 0, 1, 1);
`ifdef SIPO_FLUSH_EN
        chk("t6_flush_word", bus.out_data, 64'h1122330000000000);
        chk("t6_flush_beats", OUT_W'(bus.out_beats), OUT_W'(3));
`else
        chk("t6_flush_ignored", OUT_W'(bus.beat_cnt), OUT_W'(3));
`endif
        cyc(1, 8'h44, 0, 0);
        cyc(1, 8'h55, 0, 0);
        cyc(1, 8'h66, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 8'h77, 0, 0);
        cyc(0, 0, 0, 1);
`ifdef SIPO_FLUSH_EN
        chk("t6_pend_word", bus.out_data, 64'h4455660000000000);
`endif
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, IN_W'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
